rab_arbiter: RTL and testbench

RAB_ARBITER -- requirements
Module: rab_arbiter

---
 rtl/rab_arbiter_pkg.sv | 33 +++
 rtl/rab_wdt.sv | 40 ++++
 rtl/rab_arbiter.sv | 159 +++++++++++++++
 tb/tb_rab_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rab_arbiter_pkg.sv
// Shared definitions for the register-access-bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rab_arbiter_pkg;

   localparam int RAB_ADDR_WIDTH_DEF = 8;
   localparam int TMO_CYCLES_DEF     = 64;

   localparam logic [7:0] RAB_WR_RSP_DATA  = 8'h00;
   localparam logic [7:0] RAB_TMO_RSP_DATA = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MCU_ACC = 2'd1,
      ST_I2C_ACC = 2'd2,
      ST_RELEASE = 2'd3
   } rab_state_e;

   // A real ack wins over a coincident timeout; writes return a fixed pattern.
   function automatic logic [7:0] rab_rsp_data(input logic       acked,
                                               input logic       is_write,
                                               input logic [7:0] rdata);
      logic [7:0] rsp;
      rsp = rdata;
      if (!acked) begin
         rsp = RAB_TMO_RSP_DATA;
      end else if (is_write) begin
         rsp = RAB_WR_RSP_DATA;
      end
      return rsp;
   endfunction

endpackage

// File: rtl/rab_wdt.sv
// Access watchdog: counts cycles spent in an access and flags the final allowed cycle.
// Latency: expire_o is combinational from the count, asserted in the TMO_CYCLES-th enabled cycle.
// Backpressure: none; the counter saturates at its last value until cleared.
module rab_wdt #(
   parameter int TMO_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam logic [7:0] LAST_CNT = 8'(TMO_CYCLES - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // Clear on access entry, count while the access is open.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LAST_CNT)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && !clr_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/rab_arbiter.sv
// Two-master (MCU, I2C) arbiter onto a single register-access bus with ack timeout.
// Latency: request sampled at edge N -> strobe after N -> requester ack one cycle after rab_ack is seen.
// Backpressure: a losing requester simply holds its level request until it is granted.
module rab_arbiter
   import rab_arbiter_pkg::*;
#(
   parameter int RAB_ADDR_WIDTH = RAB_ADDR_WIDTH_DEF,
   parameter int TMO_CYCLES     = TMO_CYCLES_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mcu_rab_read,
   input  logic                      mcu_rab_write,
   input  logic [RAB_ADDR_WIDTH-1:0] mcu_rab_addr,
   input  logic [7:0]                mcu_rab_wdata,
   output logic                      mcu_rab_ack,
   output logic [7:0]                mcu_rab_rdata,
   input  logic                      i2c_rab_read,
   input  logic                      i2c_rab_write,
   input  logic [RAB_ADDR_WIDTH-1:0] i2c_rab_addr,
   input  logic [7:0]                i2c_rab_wdata,
   output logic                      i2c_rab_ack,
   output logic [7:0]                i2c_rab_rdata,
   output logic                      rab_read,
   output logic                      rab_write,
   output logic [RAB_ADDR_WIDTH-1:0] rab_addr,
   output logic [7:0]                rab_wdata,
   input  logic                      rab_ack,
   input  logic [7:0]                rab_rdata,
   output logic                      rab_tmo,
   output logic                      rab_owner
);

   rab_state_e                state_q,    state_d;
   logic                      owner_q,    owner_d;
   logic [RAB_ADDR_WIDTH-1:0] addr_q,     addr_d;
   logic [7:0]                wdata_q,    wdata_d;
   logic                      rd_q,       rd_d;
   logic                      wr_q,       wr_d;
   logic                      mcu_ack_q,  mcu_ack_d;
   logic                      i2c_ack_q,  i2c_ack_d;
   logic                      tmo_q,      tmo_d;
   logic [7:0]                mcu_rdat_q, mcu_rdat_d;
   logic [7:0]                i2c_rdat_q, i2c_rdat_d;

   logic       mcu_req, i2c_req;
   logic       grant_i2c, grant_wr;
   logic       in_acc, wdt_clr, wdt_expire;
   logic [7:0] rsp_dat;

   assign mcu_req = mcu_rab_read | mcu_rab_write;
   assign i2c_req = i2c_rab_read | i2c_rab_write;
   assign in_acc  = (state_q == ST_MCU_ACC) || (state_q == ST_I2C_ACC);

   rab_wdt #(
      .TMO_CYCLES (TMO_CYCLES)
   ) u_wdt (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (wdt_clr),
      .en_i     (in_acc),
      .expire_o (wdt_expire)
   );

   // Arbitration, next-state and next-value computation for all registered outputs.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      mcu_ack_d  = 1'b0;
      i2c_ack_d  = 1'b0;
      tmo_d      = 1'b0;
      mcu_rdat_d = mcu_rdat_q;
      i2c_rdat_d = i2c_rdat_q;
      wdt_clr    = 1'b0;
      grant_i2c  = i2c_req && (!mcu_req || !owner_q);
      grant_wr   = grant_i2c ? i2c_rab_write : mcu_rab_write;
      rsp_dat    = rab_rsp_data(rab_ack, wr_q, rab_rdata);

      unique case (state_q)
         ST_IDLE: begin
            if (mcu_req || i2c_req) begin
               state_d = grant_i2c ? ST_I2C_ACC : ST_MCU_ACC;
               owner_d = grant_i2c;
               addr_d  = grant_i2c ? i2c_rab_addr  : mcu_rab_addr;
               wdata_d = grant_i2c ? i2c_rab_wdata : mcu_rab_wdata;
               wr_d    = grant_wr;
               rd_d    = !grant_wr;
               wdt_clr = 1'b1;
            end
         end
         ST_MCU_ACC, ST_I2C_ACC: begin
            if (rab_ack || wdt_expire) begin
               state_d = ST_RELEASE;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               tmo_d   = !rab_ack;
               if (state_q == ST_MCU_ACC) begin
                  mcu_ack_d  = 1'b1;
                  mcu_rdat_d = rsp_dat;
               end else begin
                  i2c_ack_d  = 1'b1;
                  i2c_rdat_d = rsp_dat;
               end
            end
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any open access without an ack.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= 1'b1;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         mcu_ack_q  <= 1'b0;
         i2c_ack_q  <= 1'b0;
         tmo_q      <= 1'b0;
         mcu_rdat_q <= 8'h00;
         i2c_rdat_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         mcu_ack_q  <= mcu_ack_d;
         i2c_ack_q  <= i2c_ack_d;
         tmo_q      <= tmo_d;
         mcu_rdat_q <= mcu_rdat_d;
         i2c_rdat_q <= i2c_rdat_d;
      end
   end

   assign rab_read      = rd_q;
   assign rab_write     = wr_q;
   assign rab_addr      = addr_q;
   assign rab_wdata     = wdata_q;
   assign rab_tmo       = tmo_q;
   assign rab_owner     = owner_q;
   assign mcu_rab_ack   = mcu_ack_q;
   assign mcu_rab_rdata = mcu_rdat_q;
   assign i2c_rab_ack   = i2c_ack_q;
   assign i2c_rab_rdata = i2c_rdat_q;

endmodule

// File: tb/tb_rab_arbiter.sv
// Bench for rab_arbiter: directed corner cases followed by randomized contention traffic.
// The bench plays both requesters and the register file; timing expectations come from cycle arithmetic.
module tb_rab_arbiter;

   localparam int AW  = 8;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          mcu_rab_read, mcu_rab_write, mcu_rab_ack;
   logic [AW-1:0] mcu_rab_addr;
   logic [7:0]    mcu_rab_wdata, mcu_rab_rdata;
   logic          i2c_rab_read, i2c_rab_write, i2c_rab_ack;
   logic [AW-1:0] i2c_rab_addr;
   logic [7:0]    i2c_rab_wdata, i2c_rab_rdata;
   logic          rab_read, rab_write, rab_ack, rab_tmo, rab_owner;
   logic [AW-1:0] rab_addr;
   logic [7:0]    rab_wdata, rab_rdata;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic       owner_m;
   logic [7:0] rdata_m [2];

   int         pat;
   logic       first;
   logic [1:0] op [2];
   logic [7:0] ad [2];
   logic [7:0] wd [2];
   logic [7:0] rv [2];
   int         dl [2];

   rab_arbiter #(
      .RAB_ADDR_WIDTH (AW),
      .TMO_CYCLES     (TMO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mcu_rab_read  (mcu_rab_read),
      .mcu_rab_write (mcu_rab_write),
      .mcu_rab_addr  (mcu_rab_addr),
      .mcu_rab_wdata (mcu_rab_wdata),
      .mcu_rab_ack   (mcu_rab_ack),
      .mcu_rab_rdata (mcu_rab_rdata),
      .i2c_rab_read  (i2c_rab_read),
      .i2c_rab_write (i2c_rab_write),
      .i2c_rab_addr  (i2c_rab_addr),
      .i2c_rab_wdata (i2c_rab_wdata),
      .i2c_rab_ack   (i2c_rab_ack),
      .i2c_rab_rdata (i2c_rab_rdata),
      .rab_read      (rab_read),
      .rab_write     (rab_write),
      .rab_addr      (rab_addr),
      .rab_wdata     (rab_wdata),
      .rab_ack       (rab_ack),
      .rab_rdata     (rab_rdata),
      .rab_tmo       (rab_tmo),
      .rab_owner     (rab_owner)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic side, input logic rd, input logic wr,
                          input logic [7:0] a, input logic [7:0] d);
      if (side) begin
         i2c_rab_read = rd; i2c_rab_write = wr; i2c_rab_addr = a; i2c_rab_wdata = d;
      end else begin
         mcu_rab_read = rd; mcu_rab_write = wr; mcu_rab_addr = a; mcu_rab_wdata = d;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      owner_m    = 1'b1;
      rdata_m[0] = 8'h00;
      rdata_m[1] = 8'h00;
   endtask

   // Serve one access as the register file, acking after dly strobe cycles.
   task automatic do_access(input logic side, input logic wr, input logic [7:0] a,
                            input logic [7:0] d, input int dly, input logic [7:0] rd);
      int         w;
      int         len;
      int         exp_len;
      logic       tmo;
      logic [7:0] exp_rd;
      w = 0;
      while (!(rab_read || rab_write) && w < 4) begin
         @(negedge clk);
         w++;
      end
      check("grant_seen", {31'b0, rab_read | rab_write}, 1);
      check("owner", {31'b0, rab_owner}, {31'b0, side});
      check("strobe_wr", {31'b0, rab_write}, {31'b0, wr});
      check("strobe_rd", {31'b0, rab_read}, {31'b0, !wr});
      check("addr", {24'b0, rab_addr}, {24'b0, a});
      check("wdata", {24'b0, rab_wdata}, {24'b0, d});
      tmo     = (dly > TMO - 1);
      exp_len = tmo ? TMO : dly + 1;
      exp_rd  = tmo ? 8'hFF : (wr ? 8'h00 : rd);
      len = 0;
      while ((rab_read || rab_write) && len < TMO + 4) begin
         len++;
         if (len - 1 == dly) begin
            rab_ack = 1'b1; rab_rdata = rd;
         end else begin
            rab_ack = 1'b0; rab_rdata = 8'($urandom);
         end
         @(negedge clk);
      end
      rab_ack = 1'b0;
      check("strobe_len", len, exp_len);
      check("ack_granted", {31'b0, side ? i2c_rab_ack : mcu_rab_ack}, 1);
      check("ack_other", {31'b0, side ? mcu_rab_ack : i2c_rab_ack}, 0);
      check("tmo", {31'b0, rab_tmo}, {31'b0, tmo});
      check("rdata_granted", {24'b0, side ? i2c_rab_rdata : mcu_rab_rdata}, {24'b0, exp_rd});
      check("rdata_other", {24'b0, side ? mcu_rab_rdata : i2c_rab_rdata}, {24'b0, rdata_m[!side]});
      rdata_m[side] = exp_rd;
      owner_m       = side;
      set_req(side, 1'b0, 1'b0, a, d);
      @(negedge clk);
      check("ack_one_cycle", {31'b0, side ? i2c_rab_ack : mcu_rab_ack}, 0);
      check("tmo_one_cycle", {31'b0, rab_tmo}, 0);
   endtask

   initial begin
      rst = 1'b0;
      rab_ack = 1'b0;
      rab_rdata = 8'h00;
      set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      owner_m = 1'b1;
      rdata_m[0] = 8'h00;
      rdata_m[1] = 8'h00;
      @(negedge clk);
      @(negedge clk);
      check("rst_rab_read", {31'b0, rab_read}, 0);
      check("rst_rab_write", {31'b0, rab_write}, 0);
      check("rst_mcu_ack", {31'b0, mcu_rab_ack}, 0);
      check("rst_i2c_ack", {31'b0, i2c_rab_ack}, 0);
      check("rst_tmo", {31'b0, rab_tmo}, 0);
      check("rst_owner", {31'b0, rab_owner}, 1);
      check("rst_mcu_rdata", {24'b0, mcu_rab_rdata}, 0);
      check("rst_i2c_rdata", {24'b0, i2c_rab_rdata}, 0);
      rst = 1'b1;
      @(negedge clk);

      // Single MCU write acked on the first strobe cycle.
      set_req(1'b0, 1'b0, 1'b1, 8'h05, 8'hA5);
      do_access(1'b0, 1'b1, 8'h05, 8'hA5, 0, 8'h3C);

      // Contended reads right after reset: MCU first, then I2C, then again.
      do_reset();
      set_req(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
      set_req(1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
      do_access(1'b0, 1'b0, 8'h10, 8'h00, 0, 8'h11);
      do_access(1'b1, 1'b0, 8'h20, 8'h00, 0, 8'h22);
      set_req(1'b0, 1'b1, 1'b0, 8'h30, 8'h00);
      set_req(1'b1, 1'b1, 1'b0, 8'h40, 8'h00);
      first = !owner_m;
      do_access(first, 1'b0, first ? 8'h40 : 8'h30, 8'h00, 1, 8'h33);
      do_access(!first, 1'b0, first ? 8'h30 : 8'h40, 8'h00, 2, 8'h44);

      // I2C read never acked: full timeout.
      set_req(1'b1, 1'b1, 1'b0, 8'h7E, 8'h00);
      do_access(1'b1, 1'b0, 8'h7E, 8'h00, 1000, 8'h55);

      // Ack on the last allowed cycle wins over the timeout.
      set_req(1'b0, 1'b1, 1'b0, 8'h66, 8'h00);
      do_access(1'b0, 1'b0, 8'h66, 8'h00, TMO - 1, 8'h9A);

      // Read and write together behave as a write.
      set_req(1'b0, 1'b1, 1'b1, 8'h21, 8'h5A);
      do_access(1'b0, 1'b1, 8'h21, 8'h5A, 3, 8'hC3);

      // Stray ack while idle is ignored.
      rab_ack = 1'b1;
      rab_rdata = 8'hEE;
      @(negedge clk);
      @(negedge clk);
      check("stray_mcu_ack", {31'b0, mcu_rab_ack}, 0);
      check("stray_i2c_ack", {31'b0, i2c_rab_ack}, 0);
      check("stray_strobe", {30'b0, rab_read, rab_write}, 0);
      check("stray_rdata", {24'b0, mcu_rab_rdata}, {24'b0, rdata_m[0]});
      rab_ack = 1'b0;

      // Reset in the middle of an MCU access; request held through reset.
      set_req(1'b1, 1'b0, 1'b1, 8'h01, 8'h02);
      do_access(1'b1, 1'b1, 8'h01, 8'h02, 0, 8'h00);
      set_req(1'b0, 1'b1, 1'b0, 8'h44, 8'h00);
      @(negedge clk);
      check("pre_rst_strobe", {31'b0, rab_read}, 1);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_read", {31'b0, rab_read}, 0);
      check("async_rst_owner", {31'b0, rab_owner}, 1);
      check("async_rst_mcu_ack", {31'b0, mcu_rab_ack}, 0);
      @(negedge clk);
      check("rst_hold_mcu_ack", {31'b0, mcu_rab_ack}, 0);
      rst = 1'b1;
      owner_m = 1'b1;
      rdata_m[0] = 8'h00;
      rdata_m[1] = 8'h00;
      do_access(1'b0, 1'b0, 8'h44, 8'h00, 1, 8'h81);

      // Randomized traffic against the arbitration model.
      for (int it = 0; it < 40; it++) begin
         pat = $urandom_range(0, 2);
         for (int s = 0; s < 2; s++) begin
            op[s] = 2'($urandom_range(1, 3));
            ad[s] = 8'($urandom);
            wd[s] = 8'($urandom);
            rv[s] = 8'($urandom);
            dl[s] = ($urandom_range(0, 3) == 0) ? $urandom_range(TMO - 2, TMO + 2)
                                                : $urandom_range(0, 3);
         end
         if (pat == 0 || pat == 2) set_req(1'b0, op[0][0], op[0][1], ad[0], wd[0]);
         if (pat == 1 || pat == 2) set_req(1'b1, op[1][0], op[1][1], ad[1], wd[1]);
         if (pat == 2) begin
            first = !owner_m;
            do_access(first, op[first][1], ad[first], wd[first], dl[first], rv[first]);
            do_access(!first, op[!first][1], ad[!first], wd[!first], dl[!first], rv[!first]);
         end else begin
            first = (pat == 1);
            do_access(first, op[first][1], ad[first], wd[first], dl[first], rv[first]);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
